// File: rtl/l1d_bus_unit.sv
// ============================================================================
// Module   : l1d_bus_unit
// Purpose  : Bus engine below the L1 data cache. Turns the cache's request
//            levels (single read, single write-through, line fill, line
//            writeback) into single-beat 64-bit req/ack bus transactions and
//            returns fill data, beat index and completion/error strobes.
//            One request is in service at a time.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            read_req, write_through_req, read_line_req, write_line_req
//                                      request levels from the cache
//            L1_size, pa, wt_data      access size, address, write data
//            line_data, addr_count, line_write, cache_entry_refill,
//            trans_rdy, bus_error      registered results back to the cache
//            bus_req, bus_we, bus_addr, bus_size, bus_wdata
//                                      registered bus request side
//            bus_rdata, bus_ack, bus_err
//                                      bus response side
// Options  : L1_BUS_TIMEOUT_EN - per-beat watchdog; a beat that waits
//            TIMEOUT cycles is aborted exactly like bus_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1d_bus_unit #(
    parameter int LINE_BEATS = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req,
    input  logic        write_through_req,
    input  logic        read_line_req,
    input  logic        write_line_req,
    input  logic [3:0]  L1_size,
    input  logic [63:0] pa,
    input  logic [63:0] wt_data,
    output logic [63:0] line_data,
    output logic [10:0] addr_count,
    output logic        line_write,
    output logic        cache_entry_refill,
    output logic        trans_rdy,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [3:0]  bus_size,
    output logic [63:0] bus_wdata,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SGL_RD   = 3'd1,
        S_SGL_WR   = 3'd2,
        S_FILL     = 3'd3,
        S_WB_FETCH = 3'd4,
        S_WB_ISSUE = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    localparam logic [10:0] c_last_beat = 11'(LINE_BEATS - 1);
    localparam logic [63:0] c_line_mask = ~(64'(LINE_BEATS) * 64'd8 - 64'd1);
    localparam logic [3:0]  c_size_dw   = 4'b1000;

    state_t      r_state;
    logic [63:0] r_base;
    logic [10:0] r_beat;

    logic [10:0] w_beat_inc;
    logic [63:0] w_cur_addr;
    logic [63:0] w_next_addr;
    logic        w_timeout;
    logic        w_abort;

    assign w_beat_inc  = r_beat + 11'd1;
    assign w_cur_addr  = r_base + {50'd0, r_beat, 3'b000};
    assign w_next_addr = r_base + {50'd0, w_beat_inc, 3'b000};

`ifdef L1_BUS_TIMEOUT_EN
    localparam logic [31:0] c_tmo_last = 32'(TIMEOUT - 1);
    logic [31:0] r_wdog;

    // r_wdog counts completed wait cycles of the current beat, so the beat
    // is aborted in its TIMEOUT-th cycle with bus_req high.
    assign w_timeout = bus_req && (r_wdog == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst || !bus_req || bus_ack || bus_err || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 32'd1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    // An error (or watchdog expiry) outranks an ack in the same cycle.
    assign w_abort = bus_err || w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_base             <= '0;
            r_beat             <= '0;
            line_data          <= '0;
            addr_count         <= '0;
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_size           <= '0;
            bus_wdata          <= '0;
        end else begin
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    if (write_line_req) begin
                        // addr_count is already 0 here, so the SRAM word for
                        // beat 0 is ready by the end of the first fetch cycle.
                        r_base  <= pa & c_line_mask;
                        r_state <= S_WB_FETCH;
                    end else if (read_line_req) begin
                        r_base   <= pa & c_line_mask;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= pa & c_line_mask;
                        bus_size <= c_size_dw;
                        r_state  <= S_FILL;
                    end else if (write_through_req) begin
                        r_base    <= pa;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= pa;
                        bus_size  <= L1_size;
                        bus_wdata <= wt_data;
                        r_state   <= S_SGL_WR;
                    end else if (read_req) begin
                        r_base   <= pa;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= pa;
                        bus_size <= L1_size;
                        r_state  <= S_SGL_RD;
                    end
                end

                S_SGL_RD, S_SGL_WR: begin
                    if (w_abort) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_error <= 1'b1;
                        r_state   <= S_ERR;
                    end else if (bus_ack) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        trans_rdy <= 1'b1;
                        if (r_state == S_SGL_RD) begin
                            line_data <= bus_rdata;
                        end
                        r_state <= S_DONE;
                    end
                end

                S_FILL: begin
                    if (w_abort) begin
                        bus_req   <= 1'b0;
                        bus_error <= 1'b1;
                        r_state   <= S_ERR;
                    end else if (bus_ack) begin
                        line_data  <= bus_rdata;
                        addr_count <= r_beat;
                        line_write <= 1'b1;
                        if (r_beat == c_last_beat) begin
                            bus_req            <= 1'b0;
                            trans_rdy          <= 1'b1;
                            cache_entry_refill <= 1'b1;
                            r_state            <= S_DONE;
                        end else begin
                            // bus_req stays high; move straight to the next beat.
                            r_beat   <= w_beat_inc;
                            bus_addr <= w_next_addr;
                        end
                    end
                end

                S_WB_FETCH: begin
                    // bus_wdata doubles as the writeback buffer.
                    bus_wdata <= wt_data;
                    bus_req   <= 1'b1;
                    bus_we    <= 1'b1;
                    bus_size  <= c_size_dw;
                    bus_addr  <= w_cur_addr;
                    // Present the next beat's SRAM address a cycle early so its
                    // data is already valid during the next fetch cycle.
                    if (r_beat != c_last_beat) begin
                        addr_count <= w_beat_inc;
                    end
                    r_state <= S_WB_ISSUE;
                end

                S_WB_ISSUE: begin
                    if (w_abort) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_error <= 1'b1;
                        r_state   <= S_ERR;
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (r_beat == c_last_beat) begin
                            trans_rdy <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_beat  <= w_beat_inc;
                            r_state <= S_WB_FETCH;
                        end
                    end
                end

                S_DONE, S_ERR: begin
                    // Requests are ignored here; clearing addr_count readies
                    // beat 0 for a writeback accepted in the following idle cycle.
                    addr_count <= '0;
                    r_state    <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/l1d_bus_unit.md
# l1d_bus_unit

Cache-side bus engine sitting directly downstream of the L1 data cache. It serves the cache's four request levels (single read, single write-through, line fill, line writeback), sequences them into single-beat 64-bit transactions on the core's req/ack memory bus, and returns fill data, beat index, completion and error strobes to the cache. One request is in service at a time; there is no buffering beyond one beat.

## Interface
- LINE_BEATS, 64: 64-bit beats per cache line; power of two, 2..1024.
- TIMEOUT, 255: watchdog limit in cycles. Used only with L1_BUS_TIMEOUT_EN.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- read_req / write_through_req / read_line_req / write_line_req  in  1 each  request levels from L1. Each is held until trans_rdy or bus_error.
- L1_size  in  4  one-hot byte size for single accesses (0001/0010/0100/1000).
- pa  in  64  physical address of the access.
- wt_data  in  64  write data: the single-write datum, or the writeback word read from the cache SRAM.
- line_data  out  64  registered read data: fill beat or single-read datum.
- addr_count  out  11  registered beat index within the line.
- line_write  out  1  strobe: write line_data at addr_count.
- cache_entry_refill  out  1  strobe: line fill complete, update tag.
- trans_rdy  out  1  strobe: request complete.
- bus_error  out  1  strobe: request aborted.
- bus_req  out  1  bus request. Held until bus_ack or bus_err.
- bus_we  out  1  write beat.
- bus_addr  out  64  beat address.
- bus_size  out  4  one-hot size.
- bus_wdata  out  64  write data.
- bus_rdata  in  64  read data. Valid with bus_ack.
- bus_ack  in  1  beat complete.
- bus_err  in  1  beat failed. Takes priority over bus_ack in the same cycle.

## Operation
- States: IDLE, SGL_RD, SGL_WR, FILL, WB_FETCH, WB_ISSUE, DONE, ERR.
- IDLE request priority: write_line_req > read_line_req > write_through_req > read_req.
- On acceptance, register base and beat:
  - Line requests: base = pa with the low log2(LINE_BEATS*8) bits cleared; beat = 0.
  - Single requests: base = pa; no beat counter.
- SGL_RD / SGL_WR: bus_req=1 with bus_addr=base and bus_size=L1_size. SGL_WR also drives bus_we=1 and bus_wdata=wt_data, sampled at acceptance.
  - On ack: SGL_RD captures bus_rdata into line_data. Both go to DONE.
- FILL: bus_req=1, bus_addr=base+beat*8, bus_size=1000.
  - On each ack: next cycle line_data=rdata, addr_count=beat, line_write=1, then beat+1.
  - Ack of beat LINE_BEATS-1 goes to DONE.
- Writeback, per beat:
  - WB_FETCH (1 cycle): addr_count=beat, bus_req=0. The cache SRAM has 1-cycle read latency; wt_data is captured into wbuf at the end of this cycle.
  - WB_ISSUE: bus_req=1, bus_we=1, bus_wdata=wbuf, bus_size=1000, bus_addr=base+beat*8.
  - On ack: beat+1 and back to WB_FETCH. Ack of the last beat goes to DONE.
- DONE (1 cycle): trans_rdy=1.
  - After a fill, the same cycle also carries line_write for the last beat and cache_entry_refill=1.
  - Goes to IDLE.
- ERR (1 cycle): bus_error=1, then IDLE. Entered on bus_err in any bus state.
  - No trans_rdy, no cache_entry_refill.
  - Fill beats already written stay in SRAM; the tag remains invalid.
- Requests are ignored in DONE and ERR. A level still high in DONE is not re-accepted, because the cache drops it on that edge.
- Beat counter is 11 bits. It never wraps within a transfer; terminal count is LINE_BEATS-1.

## Timing
- Reset: state IDLE; every output 0, including line_data and addr_count.
- Reset mid-transfer drops bus_req at the next edge; no strobes are emitted.
- Latency, zero-wait bus (ack in first req cycle):
  - Single access: 2 cycles from acceptance to trans_rdy.
  - Fill: LINE_BEATS+1 cycles to trans_rdy.
  - Writeback: 2*LINE_BEATS+1 cycles to trans_rdy.
- bus_addr, bus_we, bus_size and bus_wdata are stable while bus_req=1.
- bus_req deasserts in the cycle after ack/err, except in FILL, where it stays high for the next beat.

## Configuration
- L1_BUS_TIMEOUT_EN defined:
  - A cycle counter runs while bus_req=1 and clears on ack/err or at each new beat.
  - On reaching TIMEOUT it goes to ERR, identical to bus_err.
- L1_BUS_TIMEOUT_EN undefined: no counter; a beat waits indefinitely; TIMEOUT unused.

## Test plan
- Single read, pa=0x8000_0010, L1_size=0100, ack after 3 cycles with rdata=0x1122_3344 -> bus_addr=0x8000_0010, bus_size=0100; one cycle after ack, trans_rdy=1 and line_data=0x1122_3344.
- Fill, LINE_BEATS=4, pa=0x1234, zero-wait, rdata=beat index -> bus_addr 0x1220,0x1228,0x1230,0x1238; line_write with addr_count 0..3 and line_data 0..3; trans_rdy and cache_entry_refill together with the last line_write.
- Writeback, LINE_BEATS=4, wt_data=0xA0+addr_count one cycle after addr_count -> bus_wdata 0xA0..0xA3 on beats 0..3; trans_rdy on cycle 9.
- bus_err on fill beat 2 -> bus_error pulses for one cycle; no trans_rdy, no cache_entry_refill; state back to IDLE.
- write_line_req and read_line_req high together -> writeback serviced first; after DONE, the fill starts at beat 0.
- L1_BUS_TIMEOUT_EN, TIMEOUT=10, no ack on a single write -> bus_error on cycle 11 after acceptance; bus_req low afterwards. rst asserted mid-fill -> all outputs 0 at the next edge.
